rename_commit_walker: RTL and testbench

- Generalised commit/recovery engine for the rename stage.
- Pops committed ops from the active-list head and returns their previous physical destination registers to the free lists.
- On a misprediction, walks the wrong-path entries and returns their physical destination registers.
- Beyond the current committer, it adds:
  - a runtime-selectable walk direction (head-pop RRMT mode or tail-pop mode);
  - a separate walk width;
  - multiple register classes;
  - free-list back-pressure;
  - a recovery-done pulse.

---
 rtl/rename_commit_walker_pkg.sv | 33 +++
 rtl/rename_commit_walker_release_stage.sv | 15 +
 rtl/rename_commit_walker.sv | 148 ++++++++++++++
 tb/tb_rename_commit_walker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rename_commit_walker_pkg.sv
// Shared types for the rename commit/recovery walker: active-list entries,
// walk phases, recovery modes and the release record sent to the free lists.
package RenameWalkerTypes;
    localparam int AL_PREG_W  = 7;
    localparam int AL_CLASS_W = 1;

    typedef logic [AL_CLASS_W-1:0] reg_class_t;

    typedef struct packed {
        logic                 write_reg;
        reg_class_t           reg_class;
        logic [AL_PREG_W-1:0] prev_dst;
        logic [AL_PREG_W-1:0] dst;
    } AlEntry;

    typedef enum logic [1:0] {
        PH_COMMIT        = 2'd0,
        PH_RECOVER_START = 2'd1,
        PH_RECOVER_COUNT = 2'd2,
        PH_RECOVER_WALK  = 2'd3
    } WalkPhase;

    typedef enum logic {
        RM_TAIL = 1'b0,
        RM_RRMT = 1'b1
    } RecoveryMode;

    typedef struct packed {
        logic                 valid;
        reg_class_t           rclass;
        logic [AL_PREG_W-1:0] preg;
    } ReleasedRegister;
endpackage

// File: rtl/rename_commit_walker_release_stage.sv
// One release lane: registers the release record so free lists see it one
// cycle after the active-list pop that produced it.
module rename_release_stage
    import RenameWalkerTypes::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  ReleasedRegister rel_d_i,
    output ReleasedRegister rel_q_o
);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rel_q_o <= '0;
        else        rel_q_o <= rel_d_i;
    end
endmodule

// File: rtl/rename_commit_walker.sv
// Rename-stage commit/recovery engine: frees prev_dst on commit, and on a
// misprediction walks wrong-path entries (head or tail) freeing their dst.
module rename_commit_walker
    import RenameWalkerTypes::*;
#(
    parameter int COMMIT_WIDTH = 4,
    parameter int WALK_WIDTH   = 4,
    parameter int AL_DEPTH     = 64,
    parameter int PREG_W       = AL_PREG_W,
    parameter int NUM_CLASSES  = 2,
    parameter int CNT_W        = $clog2(AL_DEPTH) + 1,
    parameter int LANE_W       = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     commit_valid_i,
    input  logic [LANE_W-1:0]                        commit_num_i,
    input  AlEntry [COMMIT_WIDTH-1:0]                al_entry_i,
    input  logic                                     recovery_req_i,
    input  logic                                     recovery_mode_i,
    input  logic [CNT_W-1:0]                         recovery_entry_num_i,
    input  logic [NUM_CLASSES-1:0]                   fl_ready_i,
    output logic [LANE_W-1:0]                        pop_head_num_o,
    output logic [LANE_W-1:0]                        pop_tail_num_o,
    output logic [COMMIT_WIDTH-1:0]                  rel_valid_o,
    output logic [COMMIT_WIDTH-1:0][PREG_W-1:0]      rel_preg_o,
    output logic [COMMIT_WIDTH-1:0][AL_CLASS_W-1:0]  rel_class_o,
    output logic [LANE_W-1:0]                        flush_num_o,
    output logic                                     in_recovery_o,
    output logic                                     recovery_done_o,
    output logic                                     commit_stall_o
);
    WalkPhase        phase_q;
    RecoveryMode     mode_q;
    logic [CNT_W-1:0] count_q;
    logic            done_q;

    logic [LANE_W-1:0] walk_n, walk_eff, rel_n;
    logic [LANE_W-1:0] pop_head, pop_tail, flush;
    logic              walk_block, commit_block, stall, use_prev;
    ReleasedRegister [COMMIT_WIDTH-1:0] rel_d, rel_q;

    always_comb begin
        walk_n       = (count_q < CNT_W'(WALK_WIDTH)) ? LANE_W'(count_q) : LANE_W'(WALK_WIDTH);
        walk_block   = 1'b0;
        commit_block = 1'b0;
        // A lane only blocks if it would actually release into a full class.
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (LANE_W'(i) < walk_n && al_entry_i[i].write_reg &&
                !fl_ready_i[al_entry_i[i].reg_class])
                walk_block = 1'b1;
            if (LANE_W'(i) < commit_num_i && al_entry_i[i].write_reg &&
                !fl_ready_i[al_entry_i[i].reg_class])
                commit_block = 1'b1;
        end
        walk_eff = walk_block ? '0 : walk_n;

        pop_head = '0;
        pop_tail = '0;
        flush    = '0;
        stall    = 1'b0;
        rel_n    = '0;
        use_prev = 1'b0;
        case (phase_q)
            PH_COMMIT: begin
                stall    = commit_valid_i && commit_block;
                use_prev = 1'b1;
                if (commit_valid_i && !commit_block) begin
                    pop_head = commit_num_i;
                    rel_n    = commit_num_i;
                end
            end
            PH_RECOVER_WALK: begin
                flush = walk_eff;
                rel_n = walk_eff;
                if (mode_q == RM_RRMT) pop_head = walk_eff;
                else                   pop_tail = walk_eff;
            end
            default: ;
        endcase

        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            rel_d[i]       = '0;
            rel_d[i].valid = (LANE_W'(i) < rel_n) && al_entry_i[i].write_reg;
            if (rel_d[i].valid) begin
                rel_d[i].rclass = al_entry_i[i].reg_class;
                rel_d[i].preg   = use_prev ? al_entry_i[i].prev_dst : al_entry_i[i].dst;
            end
        end

        // Pops are combinational from inputs, so hold them quiet while in reset.
        pop_head_num_o = rst_i ? pop_head : '0;
        pop_tail_num_o = rst_i ? pop_tail : '0;
        flush_num_o    = rst_i ? flush    : '0;
        commit_stall_o = rst_i & stall;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            phase_q <= PH_COMMIT;
            mode_q  <= RM_TAIL;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (recovery_req_i) begin
                phase_q <= PH_RECOVER_START;
                mode_q  <= RecoveryMode'(recovery_mode_i);
                count_q <= '0;
            end else begin
                case (phase_q)
                    PH_RECOVER_START: phase_q <= PH_RECOVER_COUNT;
                    PH_RECOVER_COUNT: begin
                        count_q <= recovery_entry_num_i;
                        phase_q <= PH_RECOVER_WALK;
                    end
                    PH_RECOVER_WALK: begin
                        count_q <= count_q - CNT_W'(walk_eff);
                        if (count_q == CNT_W'(walk_eff)) begin
                            phase_q <= PH_COMMIT;
                            done_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A new recovery may only be requested from COMMIT; otherwise the walk restarts.
    a_req_in_commit: assert property (@(posedge clk_i) disable iff (!rst_i)
        recovery_req_i |-> phase_q == PH_COMMIT);

    for (genvar g = 0; g < COMMIT_WIDTH; g++) begin : g_rel
        rename_release_stage u_rel (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .rel_d_i (rel_d[g]),
            .rel_q_o (rel_q[g])
        );
        assign rel_valid_o[g] = rel_q[g].valid;
        assign rel_preg_o[g]  = PREG_W'(rel_q[g].preg);
        assign rel_class_o[g] = rel_q[g].rclass;
    end

    assign in_recovery_o   = (phase_q != PH_COMMIT);
    assign recovery_done_o = done_q;
endmodule

// File: tb/tb_rename_commit_walker.sv
// Directed bench for rename_commit_walker: table-driven commit vectors plus
// hand-written recovery, back-pressure and reset sequences.
module tb_rename_commit_walker;
    import RenameWalkerTypes::*;

    localparam int CW = 4, LW = 3, CNTW = 7;
    typedef AlEntry [CW-1:0] ent4_t;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic              commit_valid, recovery_req, recovery_mode;
    logic [LW-1:0]     commit_num;
    ent4_t             al_entry;
    logic [CNTW-1:0]   rec_num;
    logic [1:0]        fl_ready;
    logic [LW-1:0]     pop_head, pop_tail, flush;
    logic [CW-1:0]     rel_valid;
    logic [CW-1:0][6:0] rel_preg;
    logic [CW-1:0][0:0] rel_class;
    logic              in_rec, done, stall;

    rename_commit_walker dut (
        .clk_i(clk), .rst_i(rst), .commit_valid_i(commit_valid), .commit_num_i(commit_num),
        .al_entry_i(al_entry), .recovery_req_i(recovery_req), .recovery_mode_i(recovery_mode),
        .recovery_entry_num_i(rec_num), .fl_ready_i(fl_ready), .pop_head_num_o(pop_head),
        .pop_tail_num_o(pop_tail), .rel_valid_o(rel_valid), .rel_preg_o(rel_preg),
        .rel_class_o(rel_class), .flush_num_o(flush), .in_recovery_o(in_rec),
        .recovery_done_o(done), .commit_stall_o(stall));

    int checks = 0, fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic AlEntry mk(input logic wr, input logic cls, input int prev, input int dst);
        return {wr, cls, 7'(prev), 7'(dst)};
    endfunction

    function automatic ent4_t ents(input AlEntry e0, input AlEntry e1, input AlEntry e2, input AlEntry e3);
        return {e3, e2, e1, e0};
    endfunction

    function automatic logic [27:0] pk(input int p0, input int p1, input int p2, input int p3);
        return {7'(p3), 7'(p2), 7'(p1), 7'(p0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        commit_valid = 1'b0; commit_num = '0; al_entry = '0;
        recovery_req = 1'b0; recovery_mode = 1'b0; rec_num = '0; fl_ready = 2'b11;
    endtask

    task automatic chk_rel(input string nm, input logic [3:0] rv, input logic [27:0] pr, input logic [3:0] cl);
        chk({nm, "_rv"}, 32'(rel_valid), 32'(rv));
        chk({nm, "_preg"}, 32'(rel_preg), 32'(pr));
        chk({nm, "_cls"}, 32'(rel_class), 32'(cl));
    endtask

    // Pulse recovery_req, pass START, present the count in RECOVER_COUNT.
    task automatic start_rec(input string nm, input logic mode, input int num);
        tick(); idle(); recovery_req = 1'b1; recovery_mode = mode;
        @(negedge clk);
        tick(); idle();
        @(negedge clk);
        chk({nm, "_start_inrec"}, 32'(in_rec), 1);
        chk({nm, "_start_flush"}, 32'(flush), 0);
        tick(); idle(); rec_num = CNTW'(num);
        @(negedge clk);
        chk({nm, "_count_pops"}, 32'({pop_head, pop_tail, flush}), 0);
    endtask

    typedef struct {
        logic cv; logic [2:0] num; ent4_t ent; logic [1:0] rdy;
        logic [2:0] e_pop; logic e_stall; logic [3:0] e_rv; logic [27:0] e_preg; logic [3:0] e_cls;
    } cvec_t;
    cvec_t tbl[6];

    logic [3:0] p_rv, p_cls;
    logic [27:0] p_preg;

    initial begin
        AlEntry z;
        z = mk(0, 0, 0, 0);
        tbl[0] = '{1'b1, 3'd3, ents(mk(1,0,10,1), mk(1,0,11,2), mk(0,0,12,3), mk(1,0,13,4)), 2'b11,
                   3'd3, 1'b0, 4'b0011, pk(10,11,0,0), 4'b0000};
        tbl[1] = '{1'b0, 3'd3, ents(mk(1,0,10,1), mk(1,0,11,2), z, z), 2'b11,
                   3'd0, 1'b0, 4'b0000, pk(0,0,0,0), 4'b0000};
        tbl[2] = '{1'b1, 3'd4, ents(mk(1,0,20,0), mk(1,0,21,0), mk(1,1,22,0), mk(1,0,23,0)), 2'b01,
                   3'd0, 1'b1, 4'b0000, pk(0,0,0,0), 4'b0000};
        tbl[3] = '{1'b1, 3'd4, ents(mk(1,0,20,0), mk(1,0,21,0), mk(1,1,22,0), mk(1,0,23,0)), 2'b11,
                   3'd4, 1'b0, 4'b1111, pk(20,21,22,23), 4'b0100};
        tbl[4] = '{1'b1, 3'd0, ents(mk(1,0,24,0), z, z, z), 2'b11,
                   3'd0, 1'b0, 4'b0000, pk(0,0,0,0), 4'b0000};
        tbl[5] = '{1'b1, 3'd2, ents(mk(1,1,30,5), mk(0,0,31,6), mk(1,1,32,7), mk(1,0,33,8)), 2'b10,
                   3'd2, 1'b0, 4'b0001, pk(30,0,0,0), 4'b0001};

        // Reset with a live commit request on the inputs: everything must read 0.
        idle(); commit_valid = 1'b1; commit_num = 3'd3; al_entry = tbl[0].ent;
        #3;
        chk("rst_pops", 32'({pop_head, pop_tail, flush}), 0);
        chk("rst_flags", 32'({in_rec, done, stall}), 0);
        chk("rst_rel", 32'({rel_valid, rel_preg}), 0);
        tick(); tick(); idle(); rst = 1'b1;

        p_rv = '0; p_preg = '0; p_cls = '0;
        for (int i = 0; i < 6; i++) begin
            tick(); idle();
            commit_valid = tbl[i].cv; commit_num = tbl[i].num; al_entry = tbl[i].ent; fl_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_pop_head", i), 32'(pop_head), 32'(tbl[i].e_pop));
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("v%0d_tail_flush", i), 32'({pop_tail, flush}), 0);
            chk_rel($sformatf("v%0d_prev", i), p_rv, p_preg, p_cls);
            p_rv = tbl[i].e_rv; p_preg = tbl[i].e_preg; p_cls = tbl[i].e_cls;
        end
        tick(); idle();
        @(negedge clk);
        chk_rel("v5_rel", p_rv, p_preg, p_cls);

        // Tail walk of 10 entries: 4,4,2 then return with recovery_done.
        start_rec("tail", 1'b0, 10);
        tick(); idle(); al_entry = ents(mk(1,0,0,40), mk(1,0,0,41), mk(1,0,0,42), mk(1,0,0,43));
        @(negedge clk);
        chk("tail_w1_tail", 32'(pop_tail), 4); chk("tail_w1_head", 32'(pop_head), 0);
        chk("tail_w1_flush", 32'(flush), 4);
        tick(); idle(); al_entry = ents(mk(1,0,0,50), mk(1,0,0,51), mk(1,0,0,52), mk(1,0,0,53));
        @(negedge clk);
        chk("tail_w2_tail", 32'(pop_tail), 4);
        chk_rel("tail_w2", 4'b1111, pk(40,41,42,43), 4'b0000);
        tick(); idle(); al_entry = ents(mk(1,0,0,60), mk(1,0,0,61), mk(1,0,0,62), mk(1,0,0,63));
        @(negedge clk);
        chk("tail_w3_tail", 32'(pop_tail), 2);
        chk_rel("tail_w3", 4'b1111, pk(50,51,52,53), 4'b0000);
        chk("tail_w3_done", 32'(done), 0);
        tick(); idle();
        @(negedge clk);
        chk("tail_done", 32'({done, in_rec}), 2'b10);
        chk_rel("tail_last", 4'b0011, pk(60,61,0,0), 4'b0000);
        tick(); idle();
        @(negedge clk);
        chk("tail_done_pulse", 32'(done), 0);

        // RRMT head pop of 3 entries, releasing dst not prev_dst.
        start_rec("rrmt", 1'b1, 3);
        tick(); idle(); al_entry = ents(mk(1,1,99,70), mk(0,0,98,71), mk(1,0,97,72), mk(1,0,96,73));
        @(negedge clk);
        chk("rrmt_head", 32'(pop_head), 3); chk("rrmt_tail", 32'(pop_tail), 0);
        chk("rrmt_flush", 32'(flush), 3);
        tick(); idle();
        @(negedge clk);
        chk("rrmt_done", 32'({done, in_rec}), 2'b10);
        chk_rel("rrmt", 4'b0101, pk(70,0,72,0), 4'b0001);

        // fp free list full for two cycles while lane 1 is fp; walk holds, then resumes.
        start_rec("bp", 1'b0, 5);
        tick(); idle(); fl_ready = 2'b01;
        al_entry = ents(mk(1,0,0,80), mk(1,1,0,81), mk(1,0,0,82), mk(1,0,0,83));
        @(negedge clk);
        chk("bp_s1_flush", 32'({flush, pop_tail}), 0); chk("bp_s1_inrec", 32'(in_rec), 1);
        tick();
        @(negedge clk);
        chk("bp_s2_flush", 32'({flush, pop_tail}), 0); chk("bp_s2_rv", 32'(rel_valid), 0);
        tick(); fl_ready = 2'b11;
        @(negedge clk);
        chk("bp_go_flush", 32'(flush), 4); chk("bp_go_rv", 32'(rel_valid), 0);
        tick(); idle(); al_entry = ents(mk(1,0,0,84), mk(1,1,0,85), z, z);
        @(negedge clk);
        chk("bp_last_flush", 32'(flush), 1);
        chk_rel("bp_go", 4'b1111, pk(80,81,82,83), 4'b0010);
        tick(); idle();
        @(negedge clk);
        chk("bp_done", 32'(done), 1);
        chk_rel("bp_last", 4'b0001, pk(84,0,0,0), 4'b0000);

        // Zero-length recovery: one empty walk cycle, then done.
        start_rec("zero", 1'b0, 0);
        tick(); idle(); al_entry = ents(mk(1,0,0,90), z, z, z);
        @(negedge clk);
        chk("zero_walk", 32'({in_rec, done, flush}), {1'b1, 1'b0, 3'd0});
        tick(); idle();
        @(negedge clk);
        chk("zero_done", 32'({in_rec, done}), 2'b01);
        chk("zero_rv", 32'(rel_valid), 0);

        // Asynchronous reset with 6 entries left to walk.
        start_rec("ar", 1'b0, 10);
        tick(); idle(); al_entry = ents(mk(1,0,0,40), mk(1,0,0,41), mk(1,0,0,42), mk(1,0,0,43));
        @(negedge clk);
        chk("ar_w1_flush", 32'(flush), 4);
        tick();
        @(negedge clk);
        chk("ar_w2_flush", 32'(flush), 4);
        chk("ar_w2_rv", 32'(rel_valid), 4'b1111);
        #1 rst = 1'b0;
        #1;
        chk("ar_pops", 32'({pop_head, pop_tail, flush}), 0);
        chk("ar_rel", 32'({rel_valid, rel_preg}), 0);
        chk("ar_flags", 32'({in_rec, done, stall}), 0);
        tick(); idle(); rst = 1'b1;
        @(negedge clk);
        chk("ar_post_inrec", 32'(in_rec), 0);
        tick(); idle();
        commit_valid = tbl[0].cv; commit_num = tbl[0].num; al_entry = tbl[0].ent;
        @(negedge clk);
        chk("ar_commit_pop", 32'(pop_head), 3);
        chk("ar_commit_tail", 32'({pop_tail, flush}), 0);
        tick(); idle();
        @(negedge clk);
        chk_rel("ar_commit", 4'b0011, pk(10,11,0,0), 4'b0000);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
